sonar_scheduler: RTL

Round-robin measurement scheduler for the car's ultrasonic ranging sensors. It shares one prescaled tick counter among CHANNELS sensors. For each sensor in turn it fires a trigger pulse, waits for the echo, and times the echo width in microsecond ticks. Each result lands in a per-channel distance register with a one-cycle Valid strobe, which the navigation logic samples.

---
 rtl/sonar_scheduler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sonar_scheduler.sv
// Round-robin ultrasonic ranging scheduler: fires each sensor's trigger in turn,
// times the echo width in prescaled ticks and posts per-channel results.

module sonar_result_reg #(
   parameter int W = 14
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         we,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge Clock)
      if (Reset)   q <= '0;
      else if (we) q <= d;
endmodule

module sonar_scheduler #(
   parameter int CHANNELS      = 3,
   parameter int CNT_BITS      = 14,
   parameter int TICK_DIV      = 50,
   parameter int TRIG_TICKS    = 10,
   parameter int RISE_TIMEOUT  = 5000,
   parameter int HOLDOFF_TICKS = 20000
) (
   input  logic                         Clock,
   input  logic                         Reset,
   input  logic                         Enable,
   input  logic [CHANNELS-1:0]          Echo,
   output logic [CHANNELS-1:0]          Trigger,
   output logic [CHANNELS*CNT_BITS-1:0] Results,
   output logic [$clog2(CHANNELS)-1:0]  Channel,
   output logic                         Valid,
   output logic                         Timeout
);
   localparam int CH_W  = $clog2(CHANNELS);
   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   // The shared counter is widened so holdoff/timeout limits larger than the
   // result width (e.g. 20000 ticks vs a 14-bit result) can still be reached.
   localparam int HW    = $clog2(HOLDOFF_TICKS + 1);
   localparam int RW    = $clog2(RISE_TIMEOUT + 1);
   localparam int TW    = $clog2(TRIG_TICKS + 1);
   localparam int M1    = (CNT_BITS > HW) ? CNT_BITS : HW;
   localparam int M2    = (M1 > RW) ? M1 : RW;
   localparam int TC_W  = (M2 > TW) ? M2 : TW;

   localparam logic [TC_W-1:0] TRIG_END = TC_W'(TRIG_TICKS - 1);
   localparam logic [TC_W-1:0] RISE_END = TC_W'(RISE_TIMEOUT - 1);
   localparam logic [TC_W-1:0] HOLD_END = TC_W'(HOLDOFF_TICKS - 1);
   localparam logic [TC_W-1:0] TC_SAT   = TC_W'({CNT_BITS{1'b1}});

   typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

   state_t              state, state_nxt;
   logic [CHANNELS-1:0] sync1, sync2;
   logic [PRE_W-1:0]    pre;
   logic [TC_W-1:0]     tc;
   logic [CH_W-1:0]     ptr;
   logic                tick, es, ptr_adv;
   logic                res_we, res_to;
   logic [CNT_BITS-1:0] res_d;

   assign tick = (pre == PRE_W'(TICK_DIV - 1));
   assign es   = sync2[ptr];

   // "Reaches N" transitions fire on the tick that moves tc onto N.
   always_comb begin
      state_nxt = state;
      ptr_adv   = 1'b0;
      res_we    = 1'b0;
      res_to    = 1'b0;
      res_d     = '0;
      case (state)
         IDLE:      if (Enable) state_nxt = TRIG;
         TRIG:      if (tick && tc == TRIG_END) state_nxt = WAIT_RISE;
         WAIT_RISE: begin
            if (es) state_nxt = MEASURE;
            else if (tick && tc == RISE_END) begin
               res_we    = 1'b1;
               res_to    = 1'b1;
               res_d     = '1;
               state_nxt = HOLDOFF;
            end
         end
         MEASURE: begin
            if (!es) begin
               res_we    = 1'b1;
               res_d     = tc[CNT_BITS-1:0];
               state_nxt = HOLDOFF;
            end else if (tc == TC_SAT) begin
               res_we    = 1'b1;
               res_to    = 1'b1;
               res_d     = '1;
               state_nxt = HOLDOFF;
            end
         end
         HOLDOFF: begin
            if (tick && tc == HOLD_END) begin
               ptr_adv   = 1'b1;
               state_nxt = Enable ? TRIG : IDLE;
            end
         end
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= IDLE;
         sync1   <= '0;
         sync2   <= '0;
         pre     <= '0;
         tc      <= '0;
         ptr     <= '0;
         Trigger <= '0;
         Channel <= '0;
         Valid   <= 1'b0;
         Timeout <= 1'b0;
      end else begin
         state <= state_nxt;
         sync1 <= Echo;
         sync2 <= sync1;
         if (state_nxt != state) begin
            pre <= '0;
            tc  <= '0;
         end else begin
            pre <= tick ? '0 : pre + PRE_W'(1);
            if (tick && tc != '1) tc <= tc + TC_W'(1);
         end
         if (ptr_adv) ptr <= (ptr == CH_W'(CHANNELS - 1)) ? '0 : ptr + CH_W'(1);
         Trigger <= (state == TRIG) ? (CHANNELS'(1) << ptr) : '0;
         Valid   <= res_we;
         if (res_we) begin
            Timeout <= res_to;
            Channel <= ptr;
         end
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_res
      sonar_result_reg #(.W(CNT_BITS)) u_res (
         .Clock (Clock),
         .Reset (Reset),
         .we    (res_we && ptr == CH_W'(k)),
         .d     (res_d),
         .q     (Results[k*CNT_BITS +: CNT_BITS])
      );
   end
endmodule
